// File: rtl/simon_control.sv
// Simon game control FSM: sequences INPUT -> PLAYBACK -> REPEAT -> (INPUT | DONE)
// and issues the per-cycle datapath strobes as Mealy outputs of state and status flags.
module simon_control #(
  parameter int PLAY_HOLD = 1,
  parameter int HOLD_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       legal,
  input  logic       correct_pat,
  input  logic       i_lt_last,
  input  logic       arr_full,
  output logic       mem_ld,
  output logic       i_clr,
  output logic       i_inc,
  output logic       last_inc,
  output logic       s_led_eq_pat,
  output logic [2:0] mode_leds,
  output logic       win
);

  typedef enum logic [1:0] {
    ST_INPUT    = 2'd0,
    ST_PLAYBACK = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(PLAY_HOLD - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              win_q, win_d;
  logic              hold_exp;
  logic              mem_ld_s, i_clr_s, i_inc_s, last_inc_s;

  assign hold_exp = (hold_q == HOLD_LAST);

  // State, hold counter and win flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INPUT;
      hold_q  <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
    end
  end

  // Next-state, strobe and LED decode.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    mem_ld_s     = 1'b0;
    i_clr_s      = 1'b0;
    i_inc_s      = 1'b0;
    last_inc_s   = 1'b0;
    s_led_eq_pat = 1'b1;
    mode_leds    = 3'b001;
    case (state_q)
      ST_INPUT: begin
        if (legal) begin
          mem_ld_s = 1'b1;
          i_clr_s  = 1'b1;
          state_d  = ST_PLAYBACK;
        end else begin
          state_d  = ST_INPUT;
        end
      end
      ST_PLAYBACK: begin
        s_led_eq_pat = 1'b0;
        mode_leds    = 3'b010;
        if (hold_exp && i_lt_last) begin
          i_inc_s = 1'b1;
        end else if (hold_exp) begin
          i_clr_s = 1'b1;
          state_d = ST_REPEAT;
        end else begin
          state_d = ST_PLAYBACK;
        end
      end
      ST_REPEAT: begin
        mode_leds = 3'b100;
        // A miss wins over every other flag and never sets win.
        if (!correct_pat) begin
          i_clr_s = 1'b1;
          state_d = ST_DONE;
        end else if (i_lt_last) begin
          i_inc_s = 1'b1;
        end else if (!arr_full) begin
          last_inc_s = 1'b1;
          i_clr_s    = 1'b1;
          state_d    = ST_INPUT;
        end else begin
          i_clr_s = 1'b1;
          win_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        s_led_eq_pat = 1'b0;
        mode_leds    = 3'b111;
        if (hold_exp && i_lt_last) begin
          i_inc_s = 1'b1;
        end else if (hold_exp) begin
          i_clr_s = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_INPUT;
      end
    endcase

    if (state_d != state_q) begin
      hold_d = '0;
    end else if ((state_q == ST_PLAYBACK) || (state_q == ST_DONE)) begin
      hold_d = hold_exp ? '0 : (hold_q + HOLD_W'(1));
    end else begin
      hold_d = '0;
    end
  end

  assign mem_ld   = mem_ld_s   & ~rst;
  assign i_clr    = i_clr_s    & ~rst;
  assign i_inc    = i_inc_s    & ~rst;
  assign last_inc = last_inc_s & ~rst;
  assign win      = win_q;

endmodule

// File: tb/tb_simon_control.sv
// Directed bench for simon_control with PLAY_HOLD=3; expected output vectors are
// queued when inputs are driven and compared mid-cycle against the DUT outputs.
module tb_simon_control;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       legal = 1'b0, correct_pat = 1'b0, i_lt_last = 1'b0, arr_full = 1'b0;
  logic       mem_ld, i_clr, i_inc, last_inc, s_led_eq_pat, win;
  logic [2:0] mode_leds;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [8:0] val;
  } exp_t;
  exp_t sb_q[$];

  simon_control #(.PLAY_HOLD(3), .HOLD_W(8)) dut (
    .clk(clk), .rst(rst), .legal(legal), .correct_pat(correct_pat),
    .i_lt_last(i_lt_last), .arr_full(arr_full), .mem_ld(mem_ld), .i_clr(i_clr),
    .i_inc(i_inc), .last_inc(last_inc), .s_led_eq_pat(s_led_eq_pat),
    .mode_leds(mode_leds), .win(win)
  );

  always #5 clk = ~clk;

  // {mem_ld, i_clr, i_inc, last_inc, s_led_eq_pat, mode_leds[2:0], win}
  function automatic logic [8:0] ev(input logic ml, input logic ic, input logic ii,
                                    input logic li, input logic sl,
                                    input logic [2:0] md, input logic w);
    return {ml, ic, ii, li, sl, md, w};
  endfunction

  task automatic step(input string tag, input logic r, input logic lg, input logic cp,
                      input logic il, input logic af, input logic [8:0] expv);
    exp_t       e;
    logic [8:0] obs;
    @(negedge clk);
    rst = r; legal = lg; correct_pat = cp; i_lt_last = il; arr_full = af;
    sb_q.push_back('{tag, expv});
    #1;
    obs = {mem_ld, i_clr, i_inc, last_inc, s_led_eq_pat, mode_leds, win};
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %b", tag, obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    // reset held: strobes forced low even with legal=1
    step("rst_hold",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,1,3'b001,0));
    // T2: illegal patterns are never written
    step("in_illegal0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,1,3'b001,0));
    step("in_illegal1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,1,3'b001,0));
    step("in_illegal2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ev(0,0,0,0,1,3'b001,0));
    step("in_legal",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ev(1,1,0,0,1,3'b001,0));
    // T3: PLAYBACK with hold of 3
    step("pb_w0",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb_w1",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb_inc_a",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,1,0,0,3'b010,0));
    step("pb_w2",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb_w3",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb_inc_b",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,1,0,0,3'b010,0));
    step("pb_w4",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb_w5",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb_clr",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,0,3'b010,0));
    // T4: REPEAT hit, then level complete back to INPUT
    step("rp_inc",      1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ev(0,0,1,0,1,3'b100,0));
    step("rp_level",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, ev(0,1,0,1,1,3'b100,0));
    step("in_legal2",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ev(1,1,0,0,1,3'b001,0));
    step("pb2_w0",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb2_w1",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb2_clr",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,0,3'b010,0));
    // T5: miss takes priority even with arr_full=1
    step("rp_miss",     1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ev(0,1,0,0,1,3'b100,0));
    step("dn_w0",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,3'b111,0));
    step("dn_w1",       1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,3'b111,0));
    step("dn_inc",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,1,0,0,3'b111,0));
    step("dn_w2",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b111,0));
    step("dn_w3",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b111,0));
    step("dn_clr",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,0,3'b111,0));
    step("dn_stay",     1'b0, 1'b1, 1'b1, 1'b0, 1'b0, ev(0,0,0,0,0,3'b111,0));
    // async reset out of DONE
    step("rst_done",    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,1,3'b001,0));
    step("in_legal3",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ev(1,1,0,0,1,3'b001,0));
    step("pb3_w0",      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ev(0,0,0,0,0,3'b010,0));
    // T1: reset mid-PLAYBACK takes effect without a clock edge
    step("rst_mid_pb",  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ev(0,0,0,0,1,3'b001,0));
    step("in_after_rst",1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,1,3'b001,0));
    step("in_legal4",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, ev(1,1,0,0,1,3'b001,0));
    step("pb4_w0",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb4_w1",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b010,0));
    step("pb4_clr",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,0,3'b010,0));
    // T6: full array completed -> win, last_inc suppressed
    step("rp_full",     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ev(0,1,0,0,1,3'b100,0));
    step("win_w0",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b111,1));
    step("win_w1",      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,3'b111,1));
    step("win_clr",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,1,0,0,0,3'b111,1));
    step("rst_win",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,1,3'b001,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
